// File: rtl/frame_pkg.sv
// -----------------------------------------------------------------------------
// frame_pkg
// Shared definitions for the frame parser. It holds the byte type, the default
// frame start marker and the parser FSM state encoding.
// -----------------------------------------------------------------------------
package frame_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t SYNC_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    GET_LEN = 2'd1,
    PAYLOAD = 2'd2,
    CHECK   = 2'd3
  } state_t;

endpackage

// File: rtl/frame_timeout_ctr.sv
// -----------------------------------------------------------------------------
// frame_timeout_ctr
// Idle-cycle counter for the frame parser. It counts enabled cycles, and
// o_expire fires combinationally on the enabled cycle that brings the count to
// TIMEOUT. The counter clears on that same edge.
//
// Ports
//   CLK_48MHZ  in   system clock
//   RST        in   asynchronous active-low reset
//   i_clear    in   synchronous clear (a byte was accepted)
//   i_enable   in   count this cycle (busy and idle)
//   o_expire   out  terminal count reached on this cycle
// -----------------------------------------------------------------------------
module frame_timeout_ctr #(
  parameter int TIMEOUT = 64
) (
  input  logic CLK_48MHZ,
  input  logic RST,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;
  logic          w_expire;

  // The count holds TC after TIMEOUT-1 idle cycles, so the next idle cycle is
  // the TIMEOUT-th one.
  assign w_expire = i_enable && (r_cnt == TC);
  assign o_expire = w_expire;

  always_ff @(posedge CLK_48MHZ or negedge RST) begin
    if (!RST) begin
      r_cnt <= '0;
    end else if (i_clear || w_expire) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/frame_parser.sv
// -----------------------------------------------------------------------------
// frame_parser
// Byte-stream frame parser. The frame format is SYNC_BYTE, LEN, then LEN
// payload bytes, followed by an XOR checksum byte when FRAME_PARSER_CHECKSUM_EN
// is defined. Payload bytes are re-emitted one cycle after acceptance. The
// block flags length errors, checksum errors and idle timeouts.
//
// Optional feature macro: FRAME_PARSER_CHECKSUM_EN
//   defined   : CHECK state, XOR accumulator and CHK_ERR are present. FRAME_OK
//               follows a matching checksum byte.
//   undefined : no checksum byte, CHK_ERR tied 0, FRAME_OK pulses with EOF.
//
// Ports
//   CLK_48MHZ  in   only clock
//   RST        in   asynchronous active-low reset
//   DIN_VALID  in   byte strobe
//   DIN[7:0]   in   input byte
//   PLD_DATA   out  registered payload byte
//   PLD_VALID  out  one-cycle strobe for PLD_DATA
//   SOF / EOF  out  first / last payload byte markers (with PLD_VALID)
//   FRAME_OK   out  good frame end pulse
//   LEN_ERR    out  illegal length pulse
//   CHK_ERR    out  checksum mismatch pulse
//   TMO_ERR    out  mid-frame idle timeout pulse
//   BUSY       out  FSM not in HUNT
//
// state   | meaning
// --------+-----------------------------------------------
// HUNT    | discard bytes until SYNC_BYTE
// GET_LEN | next byte is LEN; validate and load counter
// PAYLOAD | emit bytes, accumulate XOR, count down
// CHECK   | compare checksum byte with accumulated XOR
// -----------------------------------------------------------------------------
module frame_parser
  import frame_pkg::*;
#(
  parameter byte_t SYNC_BYTE = SYNC_DEFAULT,
  parameter int    MAX_LEN   = 16,
  parameter int    TIMEOUT   = 64
) (
  input  logic       CLK_48MHZ,
  input  logic       RST,
  input  logic       DIN_VALID,
  input  logic [7:0] DIN,
  output logic [7:0] PLD_DATA,
  output logic       PLD_VALID,
  output logic       SOF,
  output logic       EOF,
  output logic       FRAME_OK,
  output logic       LEN_ERR,
  output logic       CHK_ERR,
  output logic       TMO_ERR,
  output logic       BUSY
);

  localparam byte_t MAX_LEN_B = byte_t'(MAX_LEN);

  state_t r_state;
  byte_t  r_cnt;
  logic   r_first;
  logic   w_busy;
  logic   w_expire;

`ifdef FRAME_PARSER_CHECKSUM_EN
  byte_t  r_chk;
  logic   r_chk_err;
  assign CHK_ERR = r_chk_err;
`else
  assign CHK_ERR = 1'b0;
`endif

  assign w_busy = (r_state != HUNT);
  assign BUSY   = w_busy;

  frame_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .CLK_48MHZ (CLK_48MHZ),
    .RST       (RST),
    .i_clear   (DIN_VALID),
    .i_enable  (w_busy && !DIN_VALID),
    .o_expire  (w_expire)
  );

  always_ff @(posedge CLK_48MHZ or negedge RST) begin
    if (!RST) begin
      r_state   <= HUNT;
      r_cnt     <= '0;
      r_first   <= 1'b0;
      PLD_DATA  <= '0;
      PLD_VALID <= 1'b0;
      SOF       <= 1'b0;
      EOF       <= 1'b0;
      FRAME_OK  <= 1'b0;
      LEN_ERR   <= 1'b0;
      TMO_ERR   <= 1'b0;
`ifdef FRAME_PARSER_CHECKSUM_EN
      r_chk     <= '0;
      r_chk_err <= 1'b0;
`endif
    end else begin
      PLD_VALID <= 1'b0;
      SOF       <= 1'b0;
      EOF       <= 1'b0;
      FRAME_OK  <= 1'b0;
      LEN_ERR   <= 1'b0;
      TMO_ERR   <= 1'b0;
`ifdef FRAME_PARSER_CHECKSUM_EN
      r_chk_err <= 1'b0;
`endif
      // Expiry needs an idle cycle, so it never competes with an accepted byte.
      if (w_expire) begin
        TMO_ERR <= 1'b1;
        r_state <= HUNT;
      end else if (DIN_VALID) begin
        case (r_state)
          HUNT: begin
            if (DIN == SYNC_BYTE) r_state <= GET_LEN;
          end
          GET_LEN: begin
            if ((DIN == 8'd0) || (DIN > MAX_LEN_B)) begin
              LEN_ERR <= 1'b1;
              r_state <= HUNT;
            end else begin
              r_cnt   <= DIN;
              r_first <= 1'b1;
`ifdef FRAME_PARSER_CHECKSUM_EN
              r_chk   <= '0;
`endif
              r_state <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            PLD_DATA  <= DIN;
            PLD_VALID <= 1'b1;
            SOF       <= r_first;
            r_first   <= 1'b0;
            r_cnt     <= r_cnt - 1'b1;
`ifdef FRAME_PARSER_CHECKSUM_EN
            r_chk     <= r_chk ^ DIN;
`endif
            if (r_cnt == 8'd1) begin
              EOF <= 1'b1;
`ifdef FRAME_PARSER_CHECKSUM_EN
              r_state <= CHECK;
`else
              FRAME_OK <= 1'b1;
              r_state  <= HUNT;
`endif
            end
          end
          CHECK: begin
`ifdef FRAME_PARSER_CHECKSUM_EN
            if (DIN == r_chk) FRAME_OK  <= 1'b1;
            else              r_chk_err <= 1'b1;
`endif
            r_state <= HUNT;
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: doc/frame_parser.md
FRAME_PARSER -- requirements
Module: frame_parser

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 Parameter MAX_LEN, default 16, largest legal payload length in bytes (1..255).
REQ-003 Parameter TIMEOUT, default 64, idle cycles tolerated mid-frame before abort.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset: CLK_48MHZ input 1, the only clock; RST input 1, asynchronous active-low reset.
REQ-005 DIN_VALID input 1, byte strobe from the converter stage.
REQ-006 DIN input 8, byte sampled when DIN_VALID=1.
REQ-007 PLD_DATA output 8, registered payload byte.
REQ-008 PLD_VALID output 1, one-cycle strobe qualifying PLD_DATA.
REQ-009 SOF output 1, high with the first payload byte's PLD_VALID.
REQ-010 EOF output 1, high with the last payload byte's PLD_VALID.
REQ-011 FRAME_OK output 1, one-cycle pulse on a good frame end.
REQ-012 LEN_ERR, CHK_ERR, TMO_ERR outputs 1 each, one-cycle error pulses.
REQ-013 BUSY output 1, high in any state other than HUNT.

Function
REQ-014 Frame format SHALL be: SYNC_BYTE, LEN, LEN payload bytes, then a checksum byte when CHECKSUM_EN is defined.
REQ-015 The FSM SHALL have states HUNT, GET_LEN, PAYLOAD and CHECK. It SHALL advance only on cycles with DIN_VALID=1.
REQ-016 HUNT: DIN==SYNC_BYTE -> GET_LEN. Any other byte is discarded and the FSM stays in HUNT.
REQ-017 GET_LEN: a LEN of 0 or greater than MAX_LEN SHALL pulse LEN_ERR and return to HUNT. Otherwise the FSM loads the byte counter with LEN, clears the checksum and enters PAYLOAD.
REQ-018 PAYLOAD:
- Each byte SHALL appear on PLD_DATA with PLD_VALID exactly one cycle after acceptance.
- The checksum accumulator SHALL XOR each byte in.
- The byte counter SHALL decrement on each byte.
- On the last byte the FSM goes to CHECK (CHECKSUM_EN defined) or to HUNT (not defined).
REQ-019 CHECK: a byte equal to the XOR of the payload SHALL pulse FRAME_OK. A mismatch SHALL pulse CHK_ERR. The FSM then returns to HUNT.
REQ-020 SYNC_BYTE values arriving in GET_LEN, PAYLOAD or CHECK SHALL be treated as data, never as a resync.
REQ-021 Idle timeout:
- An idle counter SHALL clear on every DIN_VALID and increment on idle cycles while BUSY.
- When the counter reaches TIMEOUT, the block pulses TMO_ERR, forces HUNT and clears the counter.
- Payload bytes already emitted are not retracted.
REQ-022 Error and FRAME_OK pulses SHALL be mutually exclusive and SHALL assert the cycle after the deciding byte is accepted.
REQ-023 Back-to-back frames SHALL be accepted with zero gap: a SYNC_BYTE on the cycle after a frame's final byte starts a new frame.
REQ-024 The byte counter SHALL be 8 bits, compared against LEN without wrap. LEN=MAX_LEN SHALL be legal.

Reset
REQ-025 While RST=0, all outputs SHALL be 0, the FSM SHALL be in HUNT, and the counters and checksum SHALL be 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately, with no error pulse on release.
REQ-027 The first DIN_VALID after reset release SHALL be evaluated in HUNT.

Configuration
REQ-028 Macro FRAME_PARSER_CHECKSUM_EN:
- Defined: the CHECK state, the XOR accumulator and CHK_ERR are present. FRAME_OK pulses after a matching checksum.
- Undefined: there is no checksum byte and CHK_ERR is tied 0. FRAME_OK pulses together with EOF.

Structure
REQ-029 A shared package frame_pkg SHALL hold the FSM state enum, the default SYNC_BYTE value and the 8-bit byte type.
REQ-030 One sub-module, frame_timeout_ctr, SHALL implement the idle counter with clear, enable and expire ports.

Verification
REQ-031 With CHECKSUM_EN defined, stream A5 03 11 22 33 00 -> PLD_DATA 11,22,33 on consecutive strobes with SOF on 11 and EOF on 33; FRAME_OK one cycle after 00.
REQ-032 Stream A5 02 0F F0 00 -> CHK_ERR pulse (expected checksum FF), no FRAME_OK, BUSY low afterwards.
REQ-033 Stream A5 00, then A5 11 (MAX_LEN=16) -> two LEN_ERR pulses, no PLD_VALID.
REQ-034 Stream A5 04 01 then 64 idle cycles -> TMO_ERR on idle cycle 64, FSM in HUNT; a following A5 01 7E 7E gives FRAME_OK.
REQ-035 RST driven low during the payload of A5 03 A5 A5 .. -> outputs 0 immediately; after release, FF FF A5 01 A5 A5 yields one payload byte A5 and FRAME_OK.
REQ-036 Two frames A5 01 55 55 A5 01 66 66 with no gap -> two FRAME_OK pulses, payload 55 then 66.
